// File: rtl/ps2_key_receiver.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix decoding and a small
// key event FIFO feeding the memory-mapped key register.
module ps2_key_receiver #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int CNT_W          = 13
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          key_ack,
    input  logic                          err_clr,
    output logic [7:0]                    key_reg,
    output logic                          key_ext,
    output logic                          key_release,
    output logic                          key_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [7:0]                    err_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]       clk_sync, dat_sync;
    logic             clk_prev, fe, bit_in;
    state_t           state, state_n;
    logic [2:0]       bitcnt, bitcnt_n;
    logic [7:0]       shreg, shreg_n, code_q;
    logic             par_ok, par_n;
    logic [CNT_W-1:0] tcnt, tcnt_n;
    logic             commit_n, commit_q, err_inc;

    logic [9:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             ext_pend, rel_pend;
    logic             is_prefix, push_req, full, empty, pop, do_push, drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            clk_prev <= clk_sync[1];
        end
    end

    assign fe     = clk_prev & ~clk_sync[1];
    assign bit_in = dat_sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bitcnt   <= '0;
            shreg    <= '0;
            par_ok   <= 1'b0;
            tcnt     <= '0;
            commit_q <= 1'b0;
            code_q   <= '0;
        end else begin
            state    <= state_n;
            bitcnt   <= bitcnt_n;
            shreg    <= shreg_n;
            par_ok   <= par_n;
            tcnt     <= tcnt_n;
            commit_q <= commit_n;
            if (commit_n)
                code_q <= shreg;
        end
    end

    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        par_n    = par_ok;
        tcnt_n   = tcnt + CNT_W'(1);
        commit_n = 1'b0;
        err_inc  = 1'b0;
        if (state == IDLE)
            tcnt_n = '0;
        if (fe) begin
            tcnt_n = '0;
            case (state)
                IDLE: begin
                    if (!bit_in) begin
                        state_n  = DATA;
                        bitcnt_n = '0;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                DATA: begin
                    shreg_n  = {bit_in, shreg[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7)
                        state_n = PARITY;
                end
                PARITY: begin
                    par_n   = ^{shreg, bit_in};
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (bit_in && par_ok)
                        commit_n = 1'b1;
                    else
                        err_inc = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE && tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_n = IDLE;
            tcnt_n  = '0;
            err_inc = 1'b1;
        end
    end

    assign is_prefix = (code_q == 8'hE0) || (code_q == 8'hF0);
    assign push_req  = commit_q & ~is_prefix;
    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign pop       = key_ack & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push   = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ext_pend  <= 1'b0;
            rel_pend  <= 1'b0;
            overflow  <= 1'b0;
            err_count <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {ext_pend, rel_pend, code_q};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (commit_q) begin
                if (code_q == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (code_q == 8'hF0) begin
                    rel_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    rel_pend <= 1'b0;
                end
            end
            if (err_clr)
                overflow <= 1'b0;
            else if (drop)
                overflow <= 1'b1;
            if (err_clr)
                err_count <= '0;
            else if (err_inc && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

    assign {key_ext, key_release, key_reg} = empty ? 10'd0 : mem[rd_ptr];
    assign key_valid  = ~empty;
    assign fifo_count = count;

endmodule
